demux_big: RTL
==============

Name: demux_big

Overview:
- Pipelined, registered 1-to-C_OUTPUTS demultiplexer tree. It steers one input word plus a valid strobe to exactly one of many output registers.
- It is the write-side counterpart of the selector-driven wide read mux used for large register/statistics banks.
- The fan-out is split into levels of at most C_DIVIDER branches so wide banks close timing.
- Each output keeps its last written value and raises a one-cycle strobe when written.

Parameters:
- C_WIDTH, 32: data word width in bits.
- C_OUTPUTS, 4: number of outputs. Power of two, >= 2.
- C_DIVIDER, 2: maximum branches per tree level. Power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  pipeline advance. When 0 the whole tree stalls.
- selector  in  $clog2(C_OUTPUTS)  destination index, sampled with value_in.
- value_in  in  C_WIDTH  data word.
- valid_in  in  1  write request, sampled when enable=1.
- values_out  out  C_WIDTH x C_OUTPUTS (unpacked [0:C_OUTPUTS-1])  per-output held data.
- valid_out  out  C_OUTPUTS  one-cycle write strobe per output.

Behaviour:
- Derived constants:
  - S = log2(C_OUTPUTS); D = log2(C_DIVIDER).
  - L = ceil(S/D) levels; L = 1 when C_OUTPUTS <= C_DIVIDER.
  - R = S - (L-1)*D is the bit count used by the first level (1..D).
- Level structure:
  - Level 1 decodes selector[S-1:S-R] (MSBs).
  - Each later level decodes the next D bits, MSB first.
  - Level L's register is the output register: values_out / valid_out.
  - Each internal level node registers data, valid, and the remaining low selector bits only.
- Reset (rst_n=0 at a clock edge):
  - all values_out = 0; all valid_out = 0.
  - all internal valids = 0; internal data/selector registers = 0.
  - Reset overrides enable. A request in flight is discarded and never appears at an output.
- enable=1:
  - Every level shifts one step.
  - A node passes data/valid to the single child chosen by its selector slice. All other children receive valid=0 and hold their data.
- Latency: a request sampled at enabled edge t (valid_in=1) produces valid_out[selector]=1 and values_out[selector]=value_in after the L-th enabled edge, counting t as the first. With no stalls, that is L cycles.
- Output update rules:
  - values_out[i] updates only on an edge where its incoming valid is 1. Otherwise it holds indefinitely.
  - valid_out[i] is 1 for exactly one cycle per delivered request.
  - At most one bit of valid_out is set in any cycle.
- enable=0:
  - All internal levels hold.
  - valid_out is cleared to 0 on that edge.
  - values_out holds.
  - valid_in is ignored.
  - On re-enable, held requests resume. Each request is delivered exactly once, in order.
- Throughput:
  - One request per enabled cycle, back-to-back, no bubbles.
  - Consecutive writes to the same index each produce a strobe; the later value wins.
- valid_in=0 with enable=1 inserts a bubble. selector and value_in are don't-care in that cycle, and no output changes.
- All selector values are legal because C_OUTPUTS is a power of two. There is no out-of-range case.

Test Plan:
- C_OUTPUTS=4, C_DIVIDER=2 (L=2). Reset, then write value 0xA5A5_0001 to sel=2 for one cycle. Required: valid_out=4'b0100 exactly 2 cycles later for one cycle, values_out[2]=0xA5A5_0001, all other outputs 0.
- C_OUTPUTS=16, C_DIVIDER=4 (L=2). Back-to-back writes sel=0..15 with value=sel+0x100. Required: strobes 0..15 in order, one per cycle starting 2 cycles after the first, and values_out[i]=0x100+i.
- C_OUTPUTS=8, C_DIVIDER=4 (L=2, R=1). Write sel=5 value 0x55, then stall enable=0 for 3 cycles after the first edge. Required: valid_out stays 0 during the stall, then 0x55 is delivered to index 5 exactly once on the 2nd enabled edge, with no duplicate strobe.
- L=2 config. Issue a request, then assert rst_n=0 one cycle later. Required: no valid_out ever, all values_out 0; a post-reset write still has latency L.
- Write sel=3 with 0x11 and then 0x22 on consecutive cycles. Required: two strobes on index 3, final values_out[3]=0x22; bubbles (valid_in=0) leave all outputs unchanged.
- C_OUTPUTS=2, C_DIVIDER=4 (L=1). Write sel=1 value 0xFFFF_FFFF. Required: valid_out=2'b10 after 1 cycle, values_out[1]=0xFFFF_FFFF.

Source files
------------

// File: rtl/demux_big.sv
// demux_big: pipelined registered 1-to-C_OUTPUTS demux tree, at most C_DIVIDER branches per level.
// Outputs hold their last written word and pulse a one-cycle strobe on each delivery.
`default_nettype none

module demux_big #(
  parameter int C_WIDTH   = 32,
  parameter int C_OUTPUTS = 4,
  parameter int C_DIVIDER = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [$clog2(C_OUTPUTS)-1:0] selector,
  input  logic [C_WIDTH-1:0]           value_in,
  input  logic                         valid_in,
  output logic [C_WIDTH-1:0]           values_out [0:C_OUTPUTS-1],
  output logic [C_OUTPUTS-1:0]         valid_out
);

  localparam int S = $clog2(C_OUTPUTS);
  localparam int D = $clog2(C_DIVIDER);
  localparam int L = (S + D - 1) / D;
  localparam int R = S - (L - 1) * D;

  for (genvar k = 0; k < L; k++) begin : g_level
    // The first level takes the leftover R selector MSBs; every later level takes D bits.
    localparam int  NK   = 1 << (R + k * D);
    localparam int  SB   = (k == 0) ? R : D;
    localparam int  NP   = NK >> SB;
    localparam int  RB   = S - R - k * D;
    localparam int  PB   = RB + SB;
    localparam bit  LAST = (k == L - 1);

    logic [NP-1:0]      par_valid;
    logic [C_WIDTH-1:0] par_data [NP];
    logic [PB-1:0]      par_sel  [NP];
    logic [NK-1:0]      hit;
    logic [NK-1:0]      node_valid;
    logic [C_WIDTH-1:0] node_data [NK];

    if (k == 0) begin : g_src
      assign par_valid[0] = valid_in;
      assign par_data[0]  = value_in;
      assign par_sel[0]   = selector;
    end else begin : g_src
      for (genvar p = 0; p < NP; p++) begin : g_par
        assign par_valid[p] = g_level[k-1].node_valid[p];
        assign par_data[p]  = g_level[k-1].node_data[p];
        assign par_sel[p]   = g_level[k-1].g_sel.sel_r[p];
      end
    end

    always_comb begin
      hit = '0;
      for (int j = 0; j < NK; j++) begin
        hit[j] = par_valid[j >> SB] && (par_sel[j >> SB][PB-1 -: SB] == SB'(j));
      end
    end

    // Internal levels freeze while stalled; the output level drops its strobe instead.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        node_valid <= '0;
        for (int j = 0; j < NK; j++) node_data[j] <= '0;
      end else if (enable) begin
        node_valid <= hit;
        for (int j = 0; j < NK; j++) begin
          if (hit[j]) node_data[j] <= par_data[j >> SB];
        end
      end else if (LAST) begin
        node_valid <= '0;
      end
    end

    if (RB > 0) begin : g_sel
      logic [RB-1:0] sel_r [NK];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int j = 0; j < NK; j++) sel_r[j] <= '0;
        end else if (enable) begin
          for (int j = 0; j < NK; j++) begin
            if (hit[j]) sel_r[j] <= par_sel[j >> SB][RB-1:0];
          end
        end
      end
    end
  end

  assign valid_out = g_level[L-1].node_valid;

  for (genvar i = 0; i < C_OUTPUTS; i++) begin : g_out
    assign values_out[i] = g_level[L-1].node_data[i];
  end

endmodule

`default_nettype wire
